// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encoding and multiply/divide latencies,
// imported by both the MDU and its pipeline-side request controller.
package mdu_pkg;

   localparam int MDU_DATA_W    = 32;
   localparam int MDU_MUL_DELAY = 5;
   localparam int MDU_DIV_DELAY = 10;

   typedef enum logic [2:0] {
      MDU_READ_HI     = 3'd0,
      MDU_READ_LO     = 3'd1,
      MDU_WRITE_HI    = 3'd2,
      MDU_WRITE_LO    = 3'd3,
      MDU_START_MULT  = 3'd4,
      MDU_START_MULTU = 3'd5,
      MDU_START_DIV   = 3'd6,
      MDU_START_DIVU  = 3'd7
   } mdu_operation_t;

   function automatic logic is_start_op(input mdu_operation_t op);
      return (op == MDU_START_MULT) || (op == MDU_START_MULTU) ||
             (op == MDU_START_DIV)  || (op == MDU_START_DIVU);
   endfunction

   function automatic logic is_read_op(input mdu_operation_t op);
      return (op == MDU_READ_HI) || (op == MDU_READ_LO);
   endfunction

endpackage

// File: rtl/mdu_request_controller.sv
// Buffers one EX-stage MDU request, issues it for a single cycle once the MDU is
// idle, returns HI/LO reads as a registered pulse and watches for a stuck MDU.
module mdu_request_controller
   import mdu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_operation,
   input  logic [31:0] req_operand1,
   input  logic [31:0] req_operand2,
   input  logic        flush,
   output logic [2:0]  mdu_operation,
   output logic [31:0] mdu_operand1,
   output logic [31:0] mdu_operand2,
   output logic        mdu_start,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_data_read,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        timeout_error
);

   localparam int DATA_W = MDU_DATA_W;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic {
      ST_IDLE,
      ST_PENDING
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               capture;
   logic               issue;
   mdu_operation_t     buf_op;
   logic [DATA_W-1:0]  buf_operand1;
   logic [DATA_W-1:0]  buf_operand2;
   logic [CNT_W-1:0]   wd_count;
   logic [CNT_W-1:0]   wd_next;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Flush outranks issue; a pending request otherwise waits for an idle MDU.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      issue      = 1'b0;
      req_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !flush) begin
               capture    = 1'b1;
               state_next = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (flush) begin
               state_next = ST_IDLE;
            end else if (!mdu_busy) begin
               issue      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         buf_op       <= MDU_READ_HI;
         buf_operand1 <= '0;
         buf_operand2 <= '0;
      end else if (capture) begin
         buf_op       <= mdu_operation_t'(req_operation);
         buf_operand1 <= req_operand1;
         buf_operand2 <= req_operand2;
      end else if (state == ST_PENDING && state_next == ST_IDLE) begin
         buf_op       <= MDU_READ_HI;
         buf_operand1 <= '0;
         buf_operand2 <= '0;
      end
   end

   // The MDU applies WRITE_* on every idle cycle, so the parked value is a harmless read.
   always_comb begin
      mdu_operation = MDU_READ_HI;
      mdu_operand1  = '0;
      mdu_operand2  = '0;
      mdu_start     = 1'b0;
      if (issue) begin
         mdu_operation = buf_op;
         mdu_operand1  = buf_operand1;
         mdu_operand2  = buf_operand2;
         mdu_start     = is_start_op(buf_op);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         resp_valid <= issue && is_read_op(buf_op);
         if (issue && is_read_op(buf_op)) begin
            resp_data <= mdu_data_read;
         end
      end
   end

   always_comb begin
      wd_next = '0;
      if (mdu_busy) begin
         wd_next = (wd_count == TIMEOUT_VAL) ? wd_count : wd_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_count      <= '0;
         timeout_error <= 1'b0;
      end else begin
         wd_count <= wd_next;
         if (wd_next == TIMEOUT_VAL) begin
            timeout_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mdu_request_controller.sv
// Bench for mdu_request_controller: behavioural MDU stub, per-cycle reference model,
// directed scenarios with literal results and a randomized traffic phase.
module tb_mdu_request_controller;
   import mdu_pkg::*;

   localparam int TIMEOUT = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_operation = 3'd0;
   logic [31:0] req_operand1 = '0;
   logic [31:0] req_operand2 = '0;
   logic        flush = 1'b0;
   logic [2:0]  mdu_operation;
   logic [31:0] mdu_operand1;
   logic [31:0] mdu_operand2;
   logic        mdu_start;
   logic        mdu_busy;
   logic [31:0] mdu_data_read;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        timeout_error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;
   int wlo_cnt = 0;
   int start_cnt = 0;
   logic [31:0] rq_data[$];
   int          rq_cyc[$];

   mdu_request_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_operation(req_operation),
      .req_operand1(req_operand1), .req_operand2(req_operand2), .flush(flush),
      .mdu_operation(mdu_operation), .mdu_operand1(mdu_operand1),
      .mdu_operand2(mdu_operand2), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
      .mdu_data_read(mdu_data_read), .resp_valid(resp_valid), .resp_data(resp_data),
      .timeout_error(timeout_error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- MDU stub ----------------
   logic [31:0] s_hi, s_lo, s_res_hi, s_res_lo;
   logic        s_commit;
   int          s_cnt;
   logic        force_busy = 1'b0;

   assign mdu_busy      = force_busy || (s_cnt != 0);
   assign mdu_data_read = (mdu_operation == MDU_READ_LO) ? s_lo : s_hi;

   function automatic logic tb_is_start(input logic [2:0] op);
      return op == MDU_START_MULT || op == MDU_START_MULTU ||
             op == MDU_START_DIV  || op == MDU_START_DIVU;
   endfunction

   function automatic logic tb_is_read(input logic [2:0] op);
      return op == MDU_READ_HI || op == MDU_READ_LO;
   endfunction

   // {commit, hi, lo}; divide by zero leaves HI/LO untouched
   function automatic logic [64:0] mdu_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         MDU_START_MULT:  begin p = sa * sb; return {1'b1, p}; end
         MDU_START_MULTU: begin p = {32'd0, a} * {32'd0, b}; return {1'b1, p}; end
         MDU_START_DIV: begin
            if (b == 0) return '0;
            q = sa / sb; r = sa % sb;
            return {1'b1, r[31:0], q[31:0]};
         end
         MDU_START_DIVU: begin
            if (b == 0) return '0;
            return {1'b1, a % b, a / b};
         end
         default: return '0;
      endcase
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         s_hi <= '0; s_lo <= '0; s_cnt <= 0; s_commit <= 1'b0;
         s_res_hi <= '0; s_res_lo <= '0;
      end else if (!mdu_busy) begin
         if (mdu_operation == MDU_WRITE_HI) s_hi <= mdu_operand1;
         if (mdu_operation == MDU_WRITE_LO) s_lo <= mdu_operand1;
         if (mdu_start && tb_is_start(mdu_operation)) begin
            {s_commit, s_res_hi, s_res_lo} <= mdu_result(mdu_operation, mdu_operand1, mdu_operand2);
            s_cnt <= (mdu_operation == MDU_START_DIV || mdu_operation == MDU_START_DIVU)
                     ? MDU_DIV_DELAY : MDU_MUL_DELAY;
         end
      end else if (s_cnt != 0) begin
         s_cnt <= s_cnt - 1;
         if (s_cnt == 1 && s_commit) begin
            s_hi <= s_res_hi;
            s_lo <= s_res_lo;
         end
      end
   end

   // ---------------- reference model ----------------
   logic        m_have;
   logic [2:0]  m_op;
   logic [31:0] m_a, m_b;
   logic        m_rv;
   logic [31:0] m_rd;
   int          m_run;
   logic        m_to;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_have <= 1'b0; m_op <= 3'd0; m_a <= '0; m_b <= '0;
         m_rv <= 1'b0; m_rd <= '0; m_run <= 0; m_to <= 1'b0;
      end else begin
         if (m_have) begin
            m_have <= mdu_busy && !flush;
         end else if (req_valid && !flush) begin
            m_have <= 1'b1; m_op <= req_operation; m_a <= req_operand1; m_b <= req_operand2;
         end
         m_rv <= m_have && !mdu_busy && !flush && tb_is_read(m_op);
         if (m_have && !mdu_busy && !flush && tb_is_read(m_op))
            m_rd <= (m_op == MDU_READ_LO) ? s_lo : s_hi;
         if (mdu_busy) begin
            m_run <= (m_run < TIMEOUT) ? m_run + 1 : m_run;
            if (m_run + 1 >= TIMEOUT) m_to <= 1'b1;
         end else begin
            m_run <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic chkb(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clock) begin
      logic       iss;
      logic [2:0] e_op;
      if (reset) begin
         iss  = m_have && !mdu_busy && !flush;
         e_op = iss ? m_op : 3'(MDU_READ_HI);
         chkb("req_ready", req_ready, !m_have);
         chk("mdu_operation", {29'd0, mdu_operation}, {29'd0, e_op});
         chk("mdu_operand1", mdu_operand1, iss ? m_a : 32'd0);
         chk("mdu_operand2", mdu_operand2, iss ? m_b : 32'd0);
         chkb("mdu_start", mdu_start, iss && tb_is_start(m_op));
         chkb("resp_valid", resp_valid, m_rv);
         chk("resp_data", resp_data, m_rd);
         chkb("timeout_error", timeout_error, m_to);
         if (mdu_operation == MDU_WRITE_LO) wlo_cnt++;
         if (mdu_start) start_cnt++;
         if (resp_valid) begin
            rq_data.push_back(resp_data);
            rq_cyc.push_back(cyc);
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit ok = 0;
      req_valid = 1'b1; req_operation = op; req_operand1 = a; req_operand2 = b;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clock);
         if (req_ready) begin ok = 1; last_acc = cyc; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_accept: got no req_ready required within 200 cycles");
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string name, input logic [31:0] exp, input int acc,
                            input int exp_lat);
      int n = 0;
      logic [31:0] d;
      int c;
      while (rq_data.size() == 0 && n < 200) begin @(negedge clock); n++; end
      if (rq_data.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: got no resp_valid required one within 200 cycles", name);
      end else begin
         d = rq_data.pop_front();
         c = rq_cyc.pop_front();
         chk(name, d, exp);
         if (exp_lat >= 0) chk({name, "_latency"}, c - acc, exp_lat);
      end
      @(posedge clock); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got simulation still running required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      #1;
      chkb("reset_req_ready", req_ready, 1'b1);
      chk("reset_mdu_operation", {29'd0, mdu_operation}, 32'(MDU_READ_HI));
      chkb("reset_mdu_start", mdu_start, 1'b0);
      chkb("reset_resp_valid", resp_valid, 1'b0);
      chk("reset_resp_data", resp_data, 32'd0);
      chkb("reset_timeout", timeout_error, 1'b0);
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;

      // MTLO then MFLO with an idle MDU
      wlo_cnt = 0;
      send(MDU_WRITE_LO, 32'h0000_1234, 32'd0);
      send(MDU_READ_LO, 32'd0, 32'd0);
      acc = last_acc;
      wait_resp("mflo_after_mtlo", 32'h0000_1234, acc, 2);
      chk("write_lo_cycles", 32'(wlo_cnt), 32'd1);

      // signed MULT -3*5 then MFHI/MFLO back to back
      start_cnt = 0;
      send(MDU_START_MULT, 32'hFFFF_FFFD, 32'd5);
      send(MDU_READ_HI, 32'd0, 32'd0);
      acc = last_acc;
      send(MDU_READ_LO, 32'd0, 32'd0);
      wait_resp("mfhi_after_mult", 32'hFFFF_FFFF, acc, MDU_MUL_DELAY + 1);
      wait_resp("mflo_after_mult", 32'hFFFF_FFF1, 0, -1);
      chk("mult_start_cycles", 32'(start_cnt), 32'd1);

      // MTHI 7, DIV by zero, MFHI
      send(MDU_WRITE_HI, 32'd7, 32'd0);
      send(MDU_START_DIV, 32'd10, 32'd0);
      send(MDU_READ_HI, 32'd0, 32'd0);
      wait_resp("mfhi_after_div0", 32'd7, 0, -1);

      // flushed MTLO during a divide
      wlo_cnt = 0;
      send(MDU_START_DIV, 32'd100, 32'd7);
      send(MDU_WRITE_LO, 32'd5, 32'd0);
      chkb("mtlo_pending", req_ready, 1'b0);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      send(MDU_READ_LO, 32'd0, 32'd0);
      wait_resp("mflo_after_flush", 32'd14, 0, -1);
      chk("flushed_write_lo_cycles", 32'(wlo_cnt), 32'd0);

      // asynchronous reset with MTHI buffered
      send(MDU_START_MULT, 32'd2, 32'd3);
      send(MDU_WRITE_HI, 32'h0000_ABCD, 32'd0);
      chkb("mthi_pending", req_ready, 1'b0);
      #2 reset = 1'b0;
      #1;
      chkb("async_req_ready", req_ready, 1'b1);
      chk("async_mdu_operation", {29'd0, mdu_operation}, 32'(MDU_READ_HI));
      chk("async_mdu_operand1", mdu_operand1, 32'd0);
      chkb("async_mdu_start", mdu_start, 1'b0);
      chk("async_resp_data", resp_data, 32'd0);
      @(negedge clock); reset = 1'b1;
      rq_data.delete(); rq_cyc.delete();
      @(posedge clock); #1;
      send(MDU_READ_HI, 32'd0, 32'd0);
      wait_resp("mfhi_after_reset", 32'd0, 0, -1);

      // randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 1500; i++) begin
         req_valid     = 1'($urandom % 2);
         req_operation = 3'($urandom % 8);
         req_operand1  = $urandom;
         req_operand2  = ($urandom % 4 == 0) ? 32'd0 : $urandom;
         flush         = ($urandom % 8 == 0);
         @(posedge clock); #1;
      end
      req_valid = 1'b0; flush = 1'b0;
      repeat (30) @(posedge clock);
      #1;
      rq_data.delete(); rq_cyc.delete();

      // watchdog with a stuck-busy MDU
      force_busy = 1'b1;
      repeat (14) @(posedge clock);
      #1 chkb("timeout_at_14", timeout_error, 1'b0);
      @(posedge clock);
      #1 chkb("timeout_at_15", timeout_error, 1'b1);
      repeat (5) @(posedge clock);
      #1 force_busy = 1'b0;
      repeat (5) @(posedge clock);
      #1 chkb("timeout_sticky", timeout_error, 1'b1);
      reset = 1'b0;
      #1 chkb("timeout_cleared", timeout_error, 1'b0);
      @(negedge clock); reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
